// File: rtl/seg_scan_driver.sv
// Multiplexed active-low seven-segment scanner; steps one digit per rising edge of I_SCAN_CLK.
// Optional leading-zero blanking is enabled by defining SEG_LEAD_ZERO_BLANK_EN.
module seg_scan_driver #(
    parameter int unsigned DIGITS = 8
) (
    input  logic                  I_CLK,
    input  logic                  Rst_n,
    input  logic                  I_SCAN_CLK,
    input  logic                  I_EN,
    input  logic [4*DIGITS-1:0]   I_DATA,
    input  logic [DIGITS-1:0]     I_DP,
    output logic [DIGITS-1:0]     O_AN,
    output logic [6:0]            O_SEG,
    output logic                  O_DP
);

    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

    typedef enum logic {StShow, StBlank} state_e;

    state_e                state_q;
    logic                  scan_q, scan_q2;
    logic [IdxW-1:0]       index_q;
    logic [4*DIGITS-1:0]   frame_q;
    logic [DIGITS-1:0]     dp_q;
    logic [DIGITS-1:0]     an_q;
    logic [6:0]            seg_q;
    logic                  dp_out_q;

    logic                  tick;
    logic                  wrap;
    logic [IdxW-1:0]       index_d;
    logic [3:0]            nibble;
    logic [6:0]            seg_show;
    logic [DIGITS-1:0]     an_show;
    logic                  dp_show;
    logic                  show_blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        unique case (h)
            4'h0: hex_to_seg = 7'b1000000;
            4'h1: hex_to_seg = 7'b1111001;
            4'h2: hex_to_seg = 7'b0100100;
            4'h3: hex_to_seg = 7'b0110000;
            4'h4: hex_to_seg = 7'b0011001;
            4'h5: hex_to_seg = 7'b0010010;
            4'h6: hex_to_seg = 7'b0000010;
            4'h7: hex_to_seg = 7'b1111000;
            4'h8: hex_to_seg = 7'b0000000;
            4'h9: hex_to_seg = 7'b0010000;
            4'hA: hex_to_seg = 7'b0001000;
            4'hB: hex_to_seg = 7'b0000011;
            4'hC: hex_to_seg = 7'b1000110;
            4'hD: hex_to_seg = 7'b0100001;
            4'hE: hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    always_comb begin
        tick     = scan_q & ~scan_q2;
        wrap     = (index_q == LastIdx);
        index_d  = wrap ? '0 : index_q + 1'b1;
        nibble   = frame_q[4*int'(index_q) +: 4];
        seg_show = hex_to_seg(nibble);
        an_show  = ~(DIGITS'(1) << index_q);
        dp_show  = ~dp_q[index_q];
    end

`ifdef SEG_LEAD_ZERO_BLANK_EN
    logic [DIGITS-1:0] lz_blank;
    logic              upper_zero;

    // A digit is blanked when it and every more-significant nibble are zero.
    always_comb begin
        lz_blank   = '0;
        upper_zero = 1'b1;
        for (int i = int'(DIGITS) - 1; i > 0; i--) begin
            upper_zero  = upper_zero & (frame_q[4*i +: 4] == 4'h0);
            lz_blank[i] = upper_zero;
        end
        show_blank = lz_blank[index_q];
    end
`else
    assign show_blank = 1'b0;
`endif

    always_ff @(posedge I_CLK) begin
        if (!Rst_n) begin
            state_q  <= StShow;
            scan_q   <= 1'b0;
            scan_q2  <= 1'b0;
            index_q  <= LastIdx;
            frame_q  <= '0;
            dp_q     <= '0;
            an_q     <= '1;
            seg_q    <= 7'h7F;
            dp_out_q <= 1'b1;
        end else begin
            scan_q  <= I_SCAN_CLK;
            scan_q2 <= scan_q;
            an_q     <= '1;
            seg_q    <= 7'h7F;
            dp_out_q <= 1'b1;
            unique case (state_q)
                StShow: begin
                    if (tick && I_EN) begin
                        state_q <= StBlank;
                        index_q <= index_d;
                        // Snapshot at wrap so a whole frame shows one coherent value.
                        if (wrap) begin
                            frame_q <= I_DATA;
                            dp_q    <= I_DP;
                        end
                    end else if (I_EN && !show_blank) begin
                        an_q     <= an_show;
                        seg_q    <= seg_show;
                        dp_out_q <= dp_show;
                    end
                end
                default: begin
                    state_q <= StShow;
                    if (I_EN && !show_blank) begin
                        an_q     <= an_show;
                        seg_q    <= seg_show;
                        dp_out_q <= dp_show;
                    end
                end
            endcase
        end
    end

    assign O_AN  = an_q;
    assign O_SEG = seg_q;
    assign O_DP  = dp_out_q;

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
- Multiplexed seven-segment display scanner that consumes the divided scan clock produced by the team's clock divider.
- Treats that clock as data in the I_CLK domain and turns each rising edge into a one-cycle tick.
- On every tick it steps to the next digit and drives active-low anode and segment lines for up to 8 hex digits.
- Snapshots display data once per frame so a multi-digit value never tears mid-scan.

Parameters:
DIGITS, 8, number of scanned digits (legal 2..8); digit 0 is least significant.

Ports:
I_CLK  input  1  system clock; the only clock in the block.
Rst_n  input  1  synchronous, active-low reset; sampled on rising edge of I_CLK.
I_SCAN_CLK  input  1  divided clock from the divider, sampled as data (never used as a clock).
I_EN  input  1  display enable; 0 turns every output off.
I_DATA  input  4*DIGITS  hex nibbles; nibble i = I_DATA[4i+3:4i] for digit i.
I_DP  input  DIGITS  decimal-point request per digit, 1 = lit.
O_AN  output  DIGITS  digit enables, active-low, one-hot-low when showing.
O_SEG  output  7  segments active-low; bit6=g … bit0=a.
O_DP  output  1  decimal point, active-low.

Behaviour:
- Reset (Rst_n=0 at an I_CLK edge):
  - scan_q=0, scan_q2=0; index=DIGITS-1; frame data and DP registers=0.
  - O_AN=all 1, O_SEG=7'h7F, O_DP=1.
  - Reset mid-frame takes effect on that edge; no partial digit persists.
- Edge detect:
  - scan_q registers I_SCAN_CLK; scan_q2 registers scan_q.
  - tick = scan_q & ~scan_q2. One tick per rising edge of I_SCAN_CLK, however long it stays high.
- States (2-phase per digit):
  - SHOW: outputs drive digit[index].
  - BLANK: all outputs off for exactly one I_CLK cycle (anti-ghosting).
- Transitions:
  - SHOW with tick and I_EN=1 -> BLANK; index = (index==DIGITS-1) ? 0 : index+1.
  - BLANK -> SHOW unconditionally on the next edge.
- Latency: I_SCAN_CLK first sampled high at edge E0 -> tick during E0..E1 -> BLANK from E1 -> new digit visible from E2.
- Frame snapshot: at the edge where index wraps to 0, I_DATA and I_DP are latched into frame registers. Digits 0..DIGITS-1 of that frame all use the snapshot. Since reset index=DIGITS-1, the first tick latches and shows digit 0.
- I_EN=0:
  - Outputs forced off on the next edge; index and snapshot held; ticks ignored (not queued).
  - When I_EN returns to 1, SHOW resumes at the held index.
- Outputs are registered; no combinational path from inputs to outputs.
- Hex decode (g..a, active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- O_DP = ~dp_snapshot[index] in SHOW, 1 otherwise.
- O_AN in SHOW has only bit[index]=0.

Optional Feature:
- Macro: SEG_LEAD_ZERO_BLANK_EN.
- Defined: a digit i>0 whose snapshot nibble and all higher nibbles are 0 is blanked in its SHOW slot (O_AN all 1, O_SEG=7'h7F, O_DP=1). Digit 0 is never blanked. Scan timing is unchanged.
- Undefined: all digits are always shown, zeros included.

Test Plan:
1. Rst_n=0 for 3 cycles with I_SCAN_CLK toggling -> O_AN=8'hFF, O_SEG=7'h7F, O_DP=1 throughout.
2. I_EN=1, I_DATA=32'h76543210, I_DP=0, I_SCAN_CLK period 20 I_CLK cycles -> each tick gives 1 blank cycle, then O_AN=8'hFE with O_SEG=7'b1000000. Subsequent ticks step through digits 1..7 with correct patterns; after digit 7 it wraps to digit 0.
3. I_SCAN_CLK held high 50 cycles -> exactly one digit advance.
4. Change I_DATA from 32'h11111111 to 32'h88888888 while index=3 -> digits 4..7 still show 1 (7'b1111001). Digits show 8 only from the next wrap to digit 0.
5. Drop I_EN for 3 scan periods at index 5, then raise it -> outputs off while low; digit 5 reappears and no digits are skipped.
6. With SEG_LEAD_ZERO_BLANK_EN, I_DATA=32'h00000407 -> digits 3..7 have anode off; digits 0, 1, 2 show 7, 0, 4. With I_DATA=0 only digit 0 lights.
